sequence_game_ctrl: RTL

Parametrised successor to the single-round pattern-match game controller. It sequences a multi-level "repeat the pattern" game. Each round appends one random symbol to a stored sequence, plays the sequence on NUM_CH LEDs, then checks the player's button presses against it under an inactivity timeout. It drives the win/lose code consumed by the 7-segment message block, and exposes level and round-complete status to the top level.

---
 rtl/sequence_game_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/sequence_game_ctrl.sv
// Multi-level "repeat the pattern" game sequencer: grows a random symbol sequence one
// step per round, plays it on the LEDs, then checks the player's presses under a timeout.
module sequence_game_ctrl #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned MAX_LEN        = 8,
    parameter int unsigned SHOW_CYCLES    = 50000000,
    parameter int unsigned GAP_CYCLES     = 25000000,
    parameter int unsigned TIMEOUT_CYCLES = 250000000,
    parameter int unsigned RESULT_CYCLES  = 250000000,
    localparam int unsigned CW = $clog2(NUM_CH),
    localparam int unsigned LW = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NUM_CH-1:0] btn,
    input  logic [CW-1:0]     rnd,
    output logic [NUM_CH-1:0] led,
    output logic [2:0]        state,
    output logic [LW-1:0]     level,
    output logic [2:0]        winlose,
    output logic              round_ok
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_APPEND   = 3'd1;
    localparam logic [2:0] ST_SHOW_ON  = 3'd2;
    localparam logic [2:0] ST_SHOW_GAP = 3'd3;
    localparam logic [2:0] ST_INPUT    = 3'd4;
    localparam logic [2:0] ST_RESULT   = 3'd5;

    localparam logic [2:0] WL_PLAY = 3'd1;
    localparam logic [2:0] WL_LOSE = 3'd2;
    localparam logic [2:0] WL_WIN  = 3'd4;

    localparam int unsigned IW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned MAX_SG = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_TR = (TIMEOUT_CYCLES > RESULT_CYCLES) ? TIMEOUT_CYCLES : RESULT_CYCLES;
    localparam int unsigned MAXC   = (MAX_SG > MAX_TR) ? MAX_SG : MAX_TR;
    localparam int unsigned TW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0] SHOW_LAST    = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] RESULT_LAST  = TW'(RESULT_CYCLES - 1);

    logic [2:0]        state_reg,    state_next;
    logic [IW-1:0]     idx_reg,      idx_next;
    logic [TW-1:0]     timer_reg,    timer_next;
    logic [LW-1:0]     level_reg,    level_next;
    logic [2:0]        winlose_reg,  winlose_next;
    logic              round_ok_reg, round_ok_next;
    logic [NUM_CH-1:0] led_reg,      led_next;

    logic [CW-1:0]     mem [MAX_LEN];
    logic              mem_we;
    logic [IW-1:0]     show_addr;
    logic [CW-1:0]     show_sym;
    logic [CW-1:0]     exp_sym;
    logic [NUM_CH-1:0] show_oh;
    logic [NUM_CH-1:0] exp_oh;
    logic              idx_is_last;
    logic              level_is_max;

    // Symbol loaded into the LEDs when (re)entering SHOW_ON. From APPEND the first
    // symbol may be the one being written this very cycle, so rnd is forwarded.
    assign show_addr = (state_reg == ST_APPEND) ? '0 : idx_reg + IW'(1);
    assign show_sym  = (state_reg == ST_APPEND && level_reg == '0) ? rnd : mem[show_addr];
    assign exp_sym   = mem[idx_reg];

    genvar gi;
    for (gi = 0; gi < NUM_CH; gi++) begin : g_dec
        assign show_oh[gi] = (show_sym == CW'(gi));
        assign exp_oh[gi]  = (exp_sym == CW'(gi));
    end

    assign idx_is_last  = (LW'(idx_reg) == level_reg - LW'(1));
    assign level_is_max = (level_reg == LW'(MAX_LEN));

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        timer_next    = timer_reg;
        level_next    = level_reg;
        winlose_next  = winlose_reg;
        round_ok_next = 1'b0;
        led_next      = led_reg;
        mem_we        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                led_next     = '0;
                winlose_next = WL_PLAY;
                if (start) begin
                    level_next = '0;
                    state_next = ST_APPEND;
                end
            end

            ST_APPEND: begin
                mem_we     = 1'b1;
                level_next = level_reg + LW'(1);
                idx_next   = '0;
                timer_next = '0;
                led_next   = show_oh;
                state_next = ST_SHOW_ON;
            end

            ST_SHOW_ON: begin
                if (timer_reg == SHOW_LAST) begin
                    timer_next = '0;
                    led_next   = '0;
                    state_next = ST_SHOW_GAP;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end

            ST_SHOW_GAP: begin
                if (timer_reg == GAP_LAST) begin
                    timer_next = '0;
                    if (idx_is_last) begin
                        idx_next   = '0;
                        led_next   = '0;
                        state_next = ST_INPUT;
                    end else begin
                        idx_next   = idx_reg + IW'(1);
                        led_next   = show_oh;
                        state_next = ST_SHOW_ON;
                    end
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end

            ST_INPUT: begin
                timer_next = timer_reg + TW'(1);
                led_next   = btn;
                // A press is evaluated before the timeout so a last-cycle press still counts.
                if (btn != '0) begin
                    timer_next = '0;
                    if (btn == exp_oh) begin
                        if (!idx_is_last) begin
                            idx_next = idx_reg + IW'(1);
                        end else if (!level_is_max) begin
                            round_ok_next = 1'b1;
                            led_next      = '0;
                            state_next    = ST_APPEND;
                        end else begin
                            winlose_next = WL_WIN;
                            led_next     = '0;
                            state_next   = ST_RESULT;
                        end
                    end else begin
                        winlose_next = WL_LOSE;
                        led_next     = '0;
                        state_next   = ST_RESULT;
                    end
                end else if (timer_reg == TIMEOUT_LAST) begin
                    timer_next   = '0;
                    winlose_next = WL_LOSE;
                    led_next     = '0;
                    state_next   = ST_RESULT;
                end
            end

            ST_RESULT: begin
                led_next = '0;
                if (timer_reg == RESULT_LAST) begin
                    timer_next   = '0;
                    winlose_next = WL_PLAY;
                    level_next   = '0;
                    state_next   = ST_IDLE;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end

            default: begin
                timer_next   = '0;
                idx_next     = '0;
                level_next   = '0;
                winlose_next = WL_PLAY;
                led_next     = '0;
                state_next   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            timer_reg    <= '0;
            level_reg    <= '0;
            winlose_reg  <= WL_PLAY;
            round_ok_reg <= 1'b0;
            led_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            timer_reg    <= timer_next;
            level_reg    <= level_next;
            winlose_reg  <= winlose_next;
            round_ok_reg <= round_ok_next;
            led_reg      <= led_next;
        end
    end

    // Sequence storage needs no reset: every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[IW'(level_reg)] <= rnd;
        end
    end

    assign led      = led_reg;
    assign state    = state_reg;
    assign level    = level_reg;
    assign winlose  = winlose_reg;
    assign round_ok = round_ok_reg;

endmodule
